// File: rtl/event_broadcaster.sv
// event_broadcaster_fifo: single-clock circular FIFO, one channel of the broadcaster.
// Latency: a push at edge k is visible on o_dout/o_empty after edge k.
// Backpressure: o_full is reported to the caller; pushes when full and pops when empty are ignored.
//   Ports: clk, rst_n, i_push/i_din (write side), i_pop/o_dout (read side, o_dout = head),
//          o_full, o_empty (both derived from registered pointers only).
module event_broadcaster_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates "full" from "empty" when the index bits match.
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
endmodule

// event_broadcaster: copies each accepted publisher event into the FIFO of every subscribed channel.
// Latency: event accepted at edge k appears on dlv_valid/dlv_data after edge k; no comb pub->dlv path.
// Backpressure: DROP_MODE=0 stalls the publisher while any subscribed FIFO is full; DROP_MODE=1 never stalls and counts drops.
//   Ports: pub_valid/pub_ready/pub_data (publisher), sub_req/sub_id/sub_en -> sub_mask (subscription),
//          dlv_valid/dlv_ready/dlv_data (per-channel delivery, ch i at [i*DATA_W +: DATA_W]),
//          drop_cnt (per-channel saturating drop counters, ch i at [i*CNT_W +: CNT_W]).
module event_broadcaster #(
    parameter int DATA_W     = 32,
    parameter int NUM_SUBS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_MODE  = 0,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pub_valid,
    output logic                         pub_ready,
    input  logic [DATA_W-1:0]            pub_data,
    input  logic                         sub_req,
    input  logic [$clog2(NUM_SUBS)-1:0]  sub_id,
    input  logic                         sub_en,
    output logic [NUM_SUBS-1:0]          sub_mask,
    output logic [NUM_SUBS-1:0]          dlv_valid,
    input  logic [NUM_SUBS-1:0]          dlv_ready,
    output logic [NUM_SUBS*DATA_W-1:0]   dlv_data,
    output logic [NUM_SUBS*CNT_W-1:0]    drop_cnt
);
    logic [NUM_SUBS-1:0] r_sub_mask;
    logic [NUM_SUBS-1:0] w_full;
    logic [NUM_SUBS-1:0] w_empty;
    logic [NUM_SUBS-1:0] w_push;
    logic [NUM_SUBS-1:0] w_pop;
    logic [NUM_SUBS-1:0] w_blk_ok;
    logic                w_accept;

    // Ready looks only at registered state, so a pop in the same cycle cannot make room.
    assign w_blk_ok  = ~r_sub_mask | ~w_full;
    assign pub_ready = (DROP_MODE != 0) ? 1'b1 : &w_blk_ok;
    assign w_accept  = pub_valid && pub_ready;
    assign sub_mask  = r_sub_mask;

    // The mask written here is first used by the accept on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub_mask <= '0;
        end else if (sub_req && (32'(sub_id) < NUM_SUBS)) begin
            r_sub_mask[sub_id] <= sub_en;
        end
    end

    for (genvar g = 0; g < NUM_SUBS; g++) begin : g_ch
        logic [DATA_W-1:0] w_dout;
        logic [CNT_W-1:0]  r_drop_cnt;

        // In blocking mode an accept implies no subscribed FIFO is full, so the
        // same push term serves both modes.
        assign w_push[g] = w_accept && r_sub_mask[g] && !w_full[g];
        assign w_pop[g]  = dlv_ready[g] && !w_empty[g];

        event_broadcaster_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g]),
            .i_din   (pub_data),
            .i_pop   (w_pop[g]),
            .o_dout  (w_dout),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );

        assign dlv_valid[g] = !w_empty[g];
        // Hold the data bus at zero while idle so reset and empty channels read as 0.
        assign dlv_data[g*DATA_W +: DATA_W] = w_empty[g] ? '0 : w_dout;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_drop_cnt <= '0;
            end else if ((DROP_MODE != 0) && w_accept && r_sub_mask[g] && w_full[g] &&
                         (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end

        assign drop_cnt[g*CNT_W +: CNT_W] = r_drop_cnt;
    end
endmodule
